// File: rtl/rle_pkg.sv
// rle_pkg: shared sizes, FSM state type, coefficient type and row-slice helper for the RLE decoder
package rle_pkg;
  localparam int N_COEF = 8;
  localparam int COEF_W = 10;
  localparam int RUN_W  = 6;
  typedef enum logic [1:0] {ACCEPT, ZRUN, WVAL, FULL} state_t;
  typedef logic [COEF_W-1:0] coef_t;
  // slot i lives at [(n-i)*w-1 -: w], so slot 0 occupies the top bits of the row
  function automatic int slot_hi(input int n, input int w, input int i);
    return (n - i) * w - 1;
  endfunction
endpackage

// File: rtl/rle_row_buf.sv
// rle_row_buf: N_COEF coefficient slots with single-slot write, zero-fill from an index, global clear and packed output
module rle_row_buf #(
  parameter int N_COEF = rle_pkg::N_COEF,
  parameter int COEF_W = rle_pkg::COEF_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       fill_en,
  input  logic                       clr,
  input  logic [$clog2(N_COEF):0]    idx,
  input  logic [COEF_W-1:0]          data,
  output logic [N_COEF*COEF_W-1:0]   row
);
  import rle_pkg::*;
  localparam int PW = $clog2(N_COEF) + 1;
  logic [COEF_W-1:0] slot [N_COEF];
  // clear and zero-fill win over the single-slot write
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int k = 0; k < N_COEF; k++) slot[k] <= '0;
    else
      for (int k = 0; k < N_COEF; k++)
        if (clr || (fill_en && PW'(k) >= idx)) slot[k] <= '0;
        else if (wr_en && PW'(k) == idx) slot[k] <= data;
  for (genvar i = 0; i < N_COEF; i++) begin : g_pack
    localparam int HI = slot_hi(N_COEF, COEF_W, i);
    assign row[HI -: COEF_W] = slot[i];
  end
endmodule

// File: rtl/rle_decode.sv
// rle_decode: expands (run, value) symbols into packed rows of N_COEF coefficients; define RLE_DECODE_ERR_EN for the sticky overflow flag
module rle_decode #(
  parameter int N_COEF = rle_pkg::N_COEF,
  parameter int COEF_W = rle_pkg::COEF_W,
  parameter int RUN_W  = rle_pkg::RUN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic [RUN_W-1:0]         sym_run,
  input  logic [COEF_W-1:0]        sym_val,
  input  logic                     sym_eob,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [N_COEF*COEF_W-1:0] row_out,
  output logic                     err
);
  import rle_pkg::*;
  localparam int PW = $clog2(N_COEF) + 1;
  localparam int SW = (PW > RUN_W ? PW : RUN_W) + 1;
  state_t state, state_nx;
  logic [PW-1:0] pos, pos_nx;
  logic [RUN_W-1:0] rcnt, rcnt_nx;
  logic [COEF_W-1:0] vlat, vlat_nx, wr_data;
  logic wr_en, fill_en, clr, ovf;
  logic [SW-1:0] reach;
  assign reach = SW'(pos) + SW'(sym_run);
  // the accept cycle of a run symbol already writes its first zero, so a run r symbol costs r+1 cycles
  always_comb begin
    state_nx = state;
    pos_nx = pos;
    rcnt_nx = rcnt;
    vlat_nx = vlat;
    wr_en = 1'b0;
    fill_en = 1'b0;
    clr = 1'b0;
    ovf = 1'b0;
    wr_data = '0;
    sym_ready = 1'b0;
    row_valid = 1'b0;
    case (state)
      ACCEPT: begin
        sym_ready = reset;
        if (sym_valid) begin
          if (sym_eob) begin
            fill_en = 1'b1;
            state_nx = FULL;
          end else if (reach >= SW'(N_COEF)) begin
            fill_en = 1'b1;
            ovf = 1'b1;
            state_nx = FULL;
          end else if (sym_run == '0) begin
            wr_en = 1'b1;
            wr_data = sym_val;
            pos_nx = pos + 1'b1;
            state_nx = (pos == PW'(N_COEF - 1)) ? FULL : ACCEPT;
          end else begin
            wr_en = 1'b1;
            pos_nx = pos + 1'b1;
            rcnt_nx = sym_run - 1'b1;
            vlat_nx = sym_val;
            state_nx = (sym_run == RUN_W'(1)) ? WVAL : ZRUN;
          end
        end
      end
      ZRUN: begin
        wr_en = 1'b1;
        pos_nx = pos + 1'b1;
        rcnt_nx = rcnt - 1'b1;
        state_nx = (rcnt == RUN_W'(1)) ? WVAL : ZRUN;
      end
      WVAL: begin
        wr_en = 1'b1;
        wr_data = vlat;
        pos_nx = pos + 1'b1;
        state_nx = (pos == PW'(N_COEF - 1)) ? FULL : ACCEPT;
      end
      FULL: begin
        row_valid = 1'b1;
        if (row_ready) begin
          clr = 1'b1;
          pos_nx = '0;
          state_nx = ACCEPT;
        end
      end
      default: state_nx = ACCEPT;
    endcase
  end
  // FSM, write position, remaining run and latched value
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ACCEPT;
      pos <= '0;
      rcnt <= '0;
      vlat <= '0;
    end else begin
      state <= state_nx;
      pos <= pos_nx;
      rcnt <= rcnt_nx;
      vlat <= vlat_nx;
    end
  rle_row_buf #(.N_COEF(N_COEF), .COEF_W(COEF_W)) u_buf (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .fill_en(fill_en),
    .clr(clr),
    .idx(pos),
    .data(wr_data),
    .row(row_out)
  );
`ifdef RLE_DECODE_ERR_EN
  // sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) err <= 1'b0;
    else if (ovf) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule
